// File: rtl/doc_arb_pkg.sv
// Shared definitions for the document RAM port arbiter.
//   DOC_ADDR_W / DOC_DATA_W : default document RAM geometry
//   BLANK_CHAR              : character used to blank the document
//   doc_state_e             : arbiter FSM states
//   doc_grant_e             : which requester owned the most recent grant
//   pick_grant()            : fair choice between write and read requesters
package doc_arb_pkg;

  localparam int unsigned DOC_ADDR_W = 9;
  localparam int unsigned DOC_DATA_W = 8;
  localparam logic [DOC_DATA_W-1:0] BLANK_CHAR = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_CLEAR = 2'd3
  } doc_state_e;

  typedef enum logic {
    GNT_READ  = 1'b0,
    GNT_WRITE = 1'b1
  } doc_grant_e;

  // Write wins when it is the only requester or when read owned the last grant;
  // otherwise read wins. Callers only use the result when wr or rd is high.
  function automatic doc_grant_e pick_grant(input logic       wr,
                                            input logic       rd,
                                            input doc_grant_e last);
    if (wr && (!rd || (last == GNT_READ))) begin
      return GNT_WRITE;
    end
    return GNT_READ;
  endfunction

endpackage

// File: rtl/doc_clear_sweeper.sv
// Address generator for the document clear sweep.
//   clk, rst : clock and synchronous active-high reset
//   step     : load the current address into the RAM port this cycle and advance
//   addr     : next sweep address to be presented to the RAM
//   last     : high while the address loaded by the previous step was the final one
module doc_clear_sweeper
  import doc_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DOC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  // addr runs one ahead of the RAM port: after the final step it has already
  // wrapped to zero, ready for the next sweep. last marks that the RAM port
  // currently shows the top address, so the owner can end the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      last <= 1'b0;
    end else if (step) begin
      addr <= addr + ADDR_W'(1);
      last <= (addr == '1);
    end else begin
      last <= 1'b0;
    end
  end

endmodule

// File: rtl/doc_port_arbiter.sv
// Single-port document RAM arbiter: serves a write requester (recognizer),
// a read requester (UART messenger) and a whole-document clear sweep.
//   clk, rst                    : clock, synchronous active-high reset
//   clr_req                     : one-cycle request to blank the document
//   clr_busy / clr_done         : clear pending-or-running / one-cycle completion pulse
//   wr_req, wr_addr, wr_data    : level write request, held until wr_ack
//   wr_ack                      : pulse in the cycle the write drives the RAM
//   rd_req, rd_addr             : level read request, held until rd_ack
//   rd_ack                      : pulse in the cycle rd_addr drives the RAM
//   rd_valid, rd_data           : read result, valid one cycle after rd_ack; data holds
//   mem_a, mem_d, mem_we        : registered RAM controls
//   mem_spo                     : combinational RAM read data for mem_a
module doc_port_arbiter
  import doc_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W = DOC_ADDR_W,
  parameter int unsigned       DATA_W = DOC_DATA_W,
  parameter logic [DATA_W-1:0] BLANK  = DATA_W'(BLANK_CHAR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_spo
);

  doc_state_e  state_q, state_d;
  doc_grant_e  last_grant_q, last_grant_d;
  logic        clr_pending_q, clr_pending_d;

  logic [ADDR_W-1:0] mem_a_d;
  logic [DATA_W-1:0] mem_d_d;
  logic              mem_we_d;
  logic              wr_ack_d;
  logic              rd_ack_d;
  logic              rd_valid_d;
  logic [DATA_W-1:0] rd_data_d;
  logic              clr_busy_d;
  logic              clr_done_d;

  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_last;
  logic              sweep_step;

  // Every cycle spent in CLEAR consumes one sweep address, including the
  // IDLE->CLEAR transition that loads address zero.
  assign sweep_step = (state_d == ST_CLEAR);

  doc_clear_sweeper #(
    .ADDR_W(ADDR_W)
  ) u_sweeper (
    .clk  (clk),
    .rst  (rst),
    .step (sweep_step),
    .addr (sweep_addr),
    .last (sweep_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= GNT_READ;
      clr_pending_q <= 1'b0;
      mem_a         <= '0;
      mem_d         <= '0;
      mem_we        <= 1'b0;
      wr_ack        <= 1'b0;
      rd_ack        <= 1'b0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      clr_busy      <= 1'b0;
      clr_done      <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      clr_pending_q <= clr_pending_d;
      mem_a         <= mem_a_d;
      mem_d         <= mem_d_d;
      mem_we        <= mem_we_d;
      wr_ack        <= wr_ack_d;
      rd_ack        <= rd_ack_d;
      rd_valid      <= rd_valid_d;
      rd_data       <= rd_data_d;
      clr_busy      <= clr_busy_d;
      clr_done      <= clr_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    clr_pending_d = clr_pending_q;
    clr_done_d    = 1'b0;
    rd_valid_d    = 1'b0;
    rd_data_d     = rd_data;

    case (state_q)
      ST_IDLE: begin
        // Only a registered pending clear pre-empts requesters; a clr_req in
        // this very cycle is seen from the next IDLE on.
        if (clr_pending_q) begin
          state_d = ST_CLEAR;
        end else if (wr_req || rd_req) begin
          last_grant_d = pick_grant(wr_req, rd_req, last_grant_q);
          state_d      = (last_grant_d == GNT_WRITE) ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_READ: begin
        state_d    = ST_IDLE;
        rd_data_d  = mem_spo;
        rd_valid_d = 1'b1;
      end
      ST_CLEAR: begin
        if (sweep_last) begin
          state_d       = ST_IDLE;
          clr_pending_d = 1'b0;
          clr_done_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A clear already pending or running absorbs further requests.
    if (clr_req && !clr_pending_q && (state_q != ST_CLEAR)) begin
      clr_pending_d = 1'b1;
    end

    // RAM controls and acks are registered, so they are loaded from the state
    // being entered; they then describe the cycle spent in that state.
    mem_a_d  = mem_a;
    mem_d_d  = mem_d;
    mem_we_d = 1'b0;
    wr_ack_d = 1'b0;
    rd_ack_d = 1'b0;
    case (state_d)
      ST_WRITE: begin
        mem_a_d  = wr_addr;
        mem_d_d  = wr_data;
        mem_we_d = 1'b1;
        wr_ack_d = 1'b1;
      end
      ST_READ: begin
        mem_a_d  = rd_addr;
        rd_ack_d = 1'b1;
      end
      ST_CLEAR: begin
        mem_a_d  = sweep_addr;
        mem_d_d  = BLANK;
        mem_we_d = 1'b1;
      end
      default: begin
      end
    endcase

    clr_busy_d = clr_pending_d || (state_d == ST_CLEAR);
  end

endmodule

// File: tb/tb_doc_port_arbiter.sv
// Self-checking bench for doc_port_arbiter: a behavioural RAM, a reference
// copy of the document contents, and a throughput/fairness model of grants.
module tb_doc_port_arbiter;

  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          clr_req;
  logic          clr_busy;
  logic          clr_done;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic          mem_we;
  logic [DW-1:0] mem_spo;

  int n_checks = 0;
  int n_err    = 0;

  // Reference document contents and arbitration history.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            m_last_read;

  // Behavioural single-port RAM seen by the DUT.
  logic          preload;
  logic [DW-1:0] ram [DEPTH];

  always @(posedge clk) begin
    if (preload) ram <= ref_mem;
    else if (mem_we) ram[mem_a] <= mem_d;
  end
  assign mem_spo = ram[mem_a];

  doc_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .BLANK (8'h00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_ack   (rd_ack),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .mem_a    (mem_a),
    .mem_d    (mem_d),
    .mem_we   (mem_we),
    .mem_spo  (mem_spo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic chk_all_zero(input string where);
    chk({where, "_mem_a"},    32'(mem_a),    0);
    chk({where, "_mem_d"},    32'(mem_d),    0);
    chk({where, "_mem_we"},   32'(mem_we),   0);
    chk({where, "_wr_ack"},   32'(wr_ack),   0);
    chk({where, "_rd_ack"},   32'(rd_ack),   0);
    chk({where, "_rd_valid"}, 32'(rd_valid), 0);
    chk({where, "_rd_data"},  32'(rd_data),  0);
    chk({where, "_clr_busy"}, 32'(clr_busy), 0);
    chk({where, "_clr_done"}, 32'(clr_done), 0);
  endtask

  // Raise the selected requests and observe n cycles. The model: an ack can
  // appear one cycle after a request is seen by a free arbiter, two acks are
  // at least two cycles apart, contention favours whoever was not granted
  // last, and a read's data arrives one cycle after its ack. With hold=0 the
  // requester drops its request once acked; with hold=1 it keeps it raised.
  task automatic run_reqs(input bit w, input bit r, input bit hold, input int n,
                          input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic [AW-1:0] ra);
    bit            wp, rp, e_wack, e_rack;
    int            next_ok, rv_at;
    logic [DW-1:0] e_rdata;
    wp = w; rp = r; next_ok = 1; rv_at = -1; e_rdata = '0;
    @(negedge clk);
    wr_req = w; wr_addr = wa; wr_data = wd;
    rd_req = r; rd_addr = ra;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      e_wack = 1'b0;
      e_rack = 1'b0;
      if (k >= next_ok && (wp || rp)) begin
        if (wp && (!rp || m_last_read)) begin
          e_wack = 1'b1;
          m_last_read = 1'b0;
          ref_mem[wa] = wd;
          if (!hold) wp = 1'b0;
        end else begin
          e_rack = 1'b1;
          m_last_read = 1'b1;
          e_rdata = ref_mem[ra];
          rv_at = k + 1;
          if (!hold) rp = 1'b0;
        end
        next_ok = k + 2;
      end
      chk("wr_ack",   32'(wr_ack),   32'(e_wack));
      chk("rd_ack",   32'(rd_ack),   32'(e_rack));
      chk("mem_we",   32'(mem_we),   32'(e_wack));
      chk("rd_valid", 32'(rd_valid), 32'(rv_at == k));
      if (e_wack) begin
        chk("wr_mem_a", 32'(mem_a), 32'(wa));
        chk("wr_mem_d", 32'(mem_d), 32'(wd));
      end
      if (e_rack) chk("rd_mem_a", 32'(mem_a), 32'(ra));
      if (rv_at == k) chk("rd_data", 32'(rd_data), 32'(e_rdata));
      wr_req = wp;
      rd_req = rp;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  // Pulse clr_req and follow the sweep: consecutive blank writes to 0..DEPTH-1,
  // busy throughout, then a single done pulse. Optionally a write request is
  // raised mid-sweep (must wait for the sweep), a second clr_req is pulsed
  // mid-sweep (must be ignored), or reset is applied at address abort_at.
  task automatic sweep(input int abort_at, input bit mid_write,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int exp_addr, cyc;
    bit done;
    exp_addr = 0; cyc = 0; done = 1'b0;
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    chk("clr_busy_pending", 32'(clr_busy), 1);
    chk("clr_we_pending",   32'(mem_we),   0);
    while (!done && cyc < 1200) begin
      @(negedge clk);
      cyc++;
      clr_req = 1'b0;
      if (clr_done) begin
        done = 1'b1;
      end else begin
        chk("sweep_we",    32'(mem_we),   1);
        chk("sweep_addr",  32'(mem_a),    32'(exp_addr));
        chk("sweep_data",  32'(mem_d),    0);
        chk("sweep_busy",  32'(clr_busy), 1);
        chk("sweep_wrack", 32'(wr_ack),   0);
        chk("sweep_rdack", 32'(rd_ack),   0);
        if (exp_addr == abort_at) begin
          rst = 1'b1;
          for (int i = 0; i <= abort_at; i++) ref_mem[i] = '0;
          @(negedge clk);
          rst = 1'b0;
          m_last_read = 1'b1;
          chk_all_zero("abort");
          for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(clr_done), 0);
            chk("abort_no_we",   32'(mem_we),   0);
            chk("abort_no_busy", 32'(clr_busy), 0);
          end
          return;
        end
        exp_addr++;
        if (mid_write && exp_addr == 200) begin
          wr_req = 1'b1; wr_addr = wa; wr_data = wd;
        end
        if (exp_addr == 300) clr_req = 1'b1;
      end
    end
    chk("clr_done_seen",  32'(done),     1);
    chk("sweep_count",    32'(exp_addr), DEPTH);
    chk("done_busy",      32'(clr_busy), 0);
    chk("done_we",        32'(mem_we),   0);
    chk("done_wrack",     32'(wr_ack),   0);
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    if (mid_write) begin
      @(negedge clk);
      chk("post_sweep_wrack", 32'(wr_ack), 1);
      chk("post_sweep_we",    32'(mem_we), 1);
      chk("post_sweep_a",     32'(mem_a),  32'(wa));
      chk("post_sweep_d",     32'(mem_d),  32'(wd));
      ref_mem[wa] = wd;
      m_last_read = 1'b0;
      wr_req = 1'b0;
    end
    @(negedge clk);
    chk("done_single_pulse", 32'(clr_done), 0);
    chk("no_restart_busy",   32'(clr_busy), 0);
  endtask

  initial begin
    logic [AW-1:0] wa, ra, last_wa;
    logic [DW-1:0] wd;
    int unsigned   op;

    rst = 1'b1; clr_req = 1'b0; preload = 1'b1;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0;
    m_last_read = 1'b1;
    last_wa = 9'h025;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    preload = 1'b0;
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("idle_after_reset");

    // Directed write then read-back of the same location.
    run_reqs(1'b1, 1'b0, 1'b0, 4, 9'h025, 8'h41, 9'h000);
    run_reqs(1'b0, 1'b1, 1'b0, 4, 9'h000, 8'h00, 9'h025);

    // Both requesters held together: grants must alternate W,R,W,R.
    run_reqs(1'b1, 1'b1, 1'b1, 8, 9'h030, 8'h5A, 9'h025);

    // Randomized single and contending transactions.
    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(2, 0);
      wa = 9'($urandom);
      wd = 8'($urandom);
      ra = ($urandom_range(1, 0) == 1) ? last_wa : 9'($urandom);
      run_reqs(op != 1, op != 0, 1'b0, 4, wa, wd, ra);
      if (op != 1) last_wa = wa;
    end

    // Full sweep with a write waiting on it and an ignored second clr_req.
    sweep(-1, 1'b1, 9'h025, 8'h77);
    run_reqs(1'b0, 1'b1, 1'b0, 4, 9'h000, 8'h00, 9'h030);
    run_reqs(1'b0, 1'b1, 1'b0, 4, 9'h000, 8'h00, 9'h025);

    // Reset mid-sweep, then a fresh sweep from address zero.
    sweep(100, 1'b0, 9'h000, 8'h00);
    sweep(-1, 1'b0, 9'h000, 8'h00);
    run_reqs(1'b1, 1'b1, 1'b0, 4, 9'h1FF, 8'hC3, 9'h1FF);
    run_reqs(1'b0, 1'b1, 1'b0, 4, 9'h000, 8'h00, 9'h100);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
